// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-and-add-3, double dabble).
// One shift iteration per clock; a WIDTH-bit value converts in WIDTH cycles.
//
// Ports:
//   Clock   system clock, rising edge
//   Resetn  synchronous active-low reset
//   start   conversion request, honoured only while busy=0
//   bin     binary value, captured on the accepting edge
//   busy    high while a conversion is running
//   done    one-cycle pulse when bcd holds a new result
//   bcd     packed BCD result, digit 0 (ones) in bcd[3:0]
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StConvert} state_t;

    state_t              state;
    logic [WIDTH-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] next_scratch;
    logic [CntW-1:0]     cnt;

    // Add 3 to every digit >= 5 before the shift; each digit is independent, no carry.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Scratch half of the combined {scratch, shreg} left shift.
    assign next_scratch = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= StIdle;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CntW'(WIDTH);
                        busy    <= 1'b1;
                        state   <= StConvert;
                    end
                end
                StConvert: begin
                    scratch <= next_scratch;
                    shreg   <= shreg << 1;
                    cnt     <= cnt - CntW'(1);
                    if (cnt == CntW'(1)) begin
                        // Final iteration: publish the fully shifted scratch value.
                        bcd   <= next_scratch;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq. The driver pushes the expected
// result (decimal digits by division) and the expected done cycle on each accepted
// start; an independent monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;

    typedef struct {
        logic [4*D-1:0] bcd;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   bin = '0;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_prev = 1'b0;
    logic done_prev = 1'b0;
    logic [4*D-1:0] prev_bcd = '0;
    exp_t sb[$];

    bin2bcd_seq #(
        .WIDTH (W),
        .DIGITS(D)
    ) dut (
        .Clock (clk),
        .Resetn(rstn),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rstn;
    end

    function automatic logic [4*D-1:0] ref_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < int'(D); i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic bit digits_ok(input logic [4*D-1:0] v);
        for (int i = 0; i < int'(D); i++) begin
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_prev) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || bcd !== '0) begin
                errors++;
                $display("FAIL reset_state: got done=%b busy=%b bcd=%h, want 0 0 000",
                         done, busy, bcd);
            end
        end else if (done === 1'b1) begin
            checks++;
            if (!digits_ok(bcd)) begin
                errors++;
                $display("FAIL digit_range: got bcd=%h, want every digit <= 9", bcd);
            end
            checks++;
            if (busy !== 1'b0 || done_prev === 1'b1) begin
                errors++;
                $display("FAIL done_shape: got busy=%b prev_done=%b, want 0 0",
                         busy, done_prev);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done with bcd=%h, want no done", bcd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bcd !== e.bcd) begin
                    errors++;
                    $display("FAIL result: got bcd=%h, want %h", bcd, e.bcd);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL latency: got done at cycle %0d, want cycle %0d", cyc, e.due);
                end
            end
        end else begin
            checks++;
            if (bcd !== prev_bcd || busy !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL idle_hold: got bcd=%h busy=%b, want bcd=%h busy=%b",
                         bcd, busy, prev_bcd, sb.size() != 0);
            end
        end
        prev_bcd  = bcd;
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a conversion; returns just after the accepting edge. hold keeps start high.
    task automatic issue(input int v, input bit hold);
        int n;
        exp_t e;
        n = 0;
        bin   = W'(v);
        start = 1'b1;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL accept_timeout: got busy=%b after %0d cycles, want 0", busy, n);
        end
        tick();
        e.bcd = ref_bcd(v);
        e.due = cyc + int'(W);
        sb.push_back(e);
        if (!hold) start = 1'b0;
        bin = W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0 || done !== 1'b0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout: got %0d pending after %0d cycles, want 0",
                     sb.size(), n);
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Full-scale value
        issue(255, 1'b0);
        wait_idle();

        // Small values around the first digit boundary
        issue(0, 1'b0);
        wait_idle();
        issue(9, 1'b0);
        wait_idle();
        issue(10, 1'b0);
        wait_idle();

        // start held across two conversions
        issue(128, 1'b1);
        issue(37, 1'b0);
        wait_idle();

        // Spurious start while busy is ignored
        issue(200, 1'b0);
        tick();
        tick();
        bin   = 8'd99;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();

        // Reset in the third convert cycle aborts the conversion
        issue(77, 1'b0);
        tick();
        tick();
        rstn = 1'b0;
        tick();
        sb.delete();
        tick();
        rstn = 1'b1;
        tick();
        issue(42, 1'b0);
        wait_idle();

        // Back-to-back sweep of every input value
        for (int v = 0; v < 256; v++) begin
            issue(v, v != 255);
        end
        wait_idle();

        // Random values, random gaps, random ignored starts
        for (int k = 0; k < 40; k++) begin
            issue(int'($urandom_range(0, 255)), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                bin   = W'($urandom);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
